// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter for the register file write port (optional scoreboard: WB_SCOREBOARD_EN)
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        ex_ready_o,
  input  logic        mc_valid_i,
  input  logic [4:0]  mc_waddr_i,
  input  logic [31:0] mc_wdata_i,
  output logic        mc_ready_o,
  input  logic        mc_issue_i,
  input  logic [4:0]  mc_issue_rd_i,
  output logic        reg_wen_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic [31:0] busy_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             starve;
  logic             ex_fire, mc_fire;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;

  // EX has priority until MC has been blocked long enough to be starving
  assign starve     = (wait_q == LIMIT);
  assign ex_ready_o = rst && !(mc_valid_i && starve);
  assign mc_ready_o = rst && (!ex_valid_i || starve);
  assign ex_fire    = ex_valid_i && ex_ready_o;
  assign mc_fire    = mc_valid_i && mc_ready_o;

  // MC wait counter: counts consecutive blocked cycles, saturating at the limit
  always_comb begin
    wait_d = wait_q;
    if (!mc_valid_i || mc_fire) begin
      wait_d = '0;
    end else if (!mc_ready_o && !starve) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Capture the granted request; writes to x0 complete but never enable the port
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (ex_fire) begin
      wen_d   = (ex_waddr_i != 5'd0);
      waddr_d = ex_waddr_i;
      wdata_d = ex_wdata_i;
    end else if (mc_fire) begin
      wen_d   = (mc_waddr_i != 5'd0);
      waddr_d = mc_waddr_i;
      wdata_d = mc_wdata_i;
    end
  end

  // Arbiter and output-stage state; reset drops any captured write
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      wait_q  <= wait_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign reg_wen_o   = wen_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Pending-write scoreboard: MC transfer clears, issue sets, set wins on a tie
  always_comb begin
    busy_d = busy_q;
    if (mc_fire) begin
      busy_d[mc_waddr_i] = 1'b0;
    end
    if (mc_issue_i && (mc_issue_rd_i != 5'd0)) begin
      busy_d[mc_issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
`else
  logic unused_issue;
  assign unused_issue = ^{mc_issue_i, mc_issue_rd_i};
  assign busy_o       = 32'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

  localparam int LIMIT = 4;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ex_valid_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_ready_o;
  logic        mc_valid_i;
  logic [4:0]  mc_waddr_i;
  logic [31:0] mc_wdata_i;
  logic        mc_ready_o;
  logic        mc_issue_i;
  logic [4:0]  mc_issue_rd_i;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic [31:0] busy_o;

  wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_ready_o(ex_ready_o),
    .mc_valid_i(mc_valid_i), .mc_waddr_i(mc_waddr_i), .mc_wdata_i(mc_wdata_i), .mc_ready_o(mc_ready_o),
    .mc_issue_i(mc_issue_i), .mc_issue_rd_i(mc_issue_rd_i),
    .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        exv; logic [4:0] exa; logic [31:0] exd;
    logic        mcv; logic [4:0] mca; logic [31:0] mcd;
    logic        iss; logic [4:0] isr;
    logic        exr; logic mcr;
    logic        wen; logic [4:0] wa; logic [31:0] wd; logic [31:0] busy;
  } vec_t;

  vec_t vecs[20];

  // Reference model: spec-level state
  int          m_blocked;
  logic        m_wen;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_busy;

  task automatic mstep(output logic dut_mcr, output logic exf, output logic mcf);
    logic st, e_exr, e_mcr;
    #1;
    st    = (m_blocked == LIMIT);
    e_exr = rst && !(mc_valid_i && st);
    e_mcr = rst && (!ex_valid_i || st);
    chk("m_ex_ready", ex_ready_o, e_exr);
    chk("m_mc_ready", mc_ready_o, e_mcr);
    dut_mcr = mc_ready_o;
    exf = rst && ex_valid_i && e_exr;
    mcf = rst && mc_valid_i && e_mcr;
    @(posedge clk);
    if (!rst) begin
      m_blocked = 0; m_wen = 0; m_wa = 0; m_wd = 0; m_busy = 0;
    end else begin
      m_wen = 0;
      if (exf) begin
        m_wen = (ex_waddr_i != 0); m_wa = ex_waddr_i; m_wd = ex_wdata_i;
      end else if (mcf) begin
        m_wen = (mc_waddr_i != 0); m_wa = mc_waddr_i; m_wd = mc_wdata_i;
      end
      if (mc_valid_i && !mcf) m_blocked = (m_blocked < LIMIT) ? m_blocked + 1 : LIMIT;
      else m_blocked = 0;
      if (mcf) m_busy[mc_waddr_i] = 1'b0;
      if (mc_issue_i && mc_issue_rd_i != 0) m_busy[mc_issue_rd_i] = 1'b1;
    end
    #1;
    chk("m_wen", reg_wen_o, m_wen);
    chk("m_waddr", reg_waddr_o, m_wa);
    chk("m_wdata", reg_wdata_o, m_wd);
    chk("m_busy", busy_o, SB ? m_busy : 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic dmcr, exf, mcf, redo;
    int n;
    clk = 0; rst = 0;
    ex_valid_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    mc_valid_i = 0; mc_waddr_i = 0; mc_wdata_i = 0;
    mc_issue_i = 0; mc_issue_rd_i = 0;

    //            rst exv exa exd           mcv mca mcd    iss isr exr mcr wen wa wd            busy
    vecs[0]  = '{0, 1, 3, 32'h11,        1, 7, 32'h77, 0, 0,  0, 0,  0, 0, 32'h0,        32'h0};
    vecs[1]  = '{0, 1, 3, 32'h11,        1, 7, 32'h77, 0, 0,  0, 0,  0, 0, 32'h0,        32'h0};
    vecs[2]  = '{0, 1, 3, 32'h11,        1, 7, 32'h77, 0, 0,  0, 0,  0, 0, 32'h0,        32'h0};
    vecs[3]  = '{1, 1, 3, 32'h11,        1, 8, 32'h88, 0, 0,  1, 0,  1, 3, 32'h11,       32'h0};
    vecs[4]  = '{1, 1, 5, 32'hDEADBEEF,  1, 8, 32'h88, 0, 0,  1, 0,  1, 5, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1, 0, 0, 32'h0,         1, 8, 32'h88, 0, 0,  1, 1,  1, 8, 32'h88,       32'h0};
    vecs[6]  = '{1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  1, 1,  0, 8, 32'h88,       32'h0};
    vecs[7]  = '{1, 1, 1, 32'h100,       1, 7, 32'h77, 1, 7,  1, 0,  1, 1, 32'h100,      32'h80};
    vecs[8]  = '{1, 1, 2, 32'h200,       1, 7, 32'h77, 0, 0,  1, 0,  1, 2, 32'h200,      32'h80};
    vecs[9]  = '{1, 1, 3, 32'h300,       1, 7, 32'h77, 0, 0,  1, 0,  1, 3, 32'h300,      32'h80};
    vecs[10] = '{1, 1, 4, 32'h400,       1, 7, 32'h77, 0, 0,  1, 0,  1, 4, 32'h400,      32'h80};
    vecs[11] = '{1, 1, 5, 32'h500,       1, 7, 32'h77, 0, 0,  0, 1,  1, 7, 32'h77,       32'h0};
    vecs[12] = '{1, 1, 5, 32'h500,       0, 0, 32'h0,  0, 0,  1, 0,  1, 5, 32'h500,      32'h0};
    vecs[13] = '{1, 0, 0, 32'h0,         1, 0, 32'h1234, 1, 9, 1, 1, 0, 0, 32'h1234,     32'h200};
    vecs[14] = '{1, 0, 0, 32'h0,         1, 9, 32'h99, 1, 9,  1, 1,  1, 9, 32'h99,       32'h200};
    vecs[15] = '{1, 0, 0, 32'h0,         1, 9, 32'h9A, 0, 0,  1, 1,  1, 9, 32'h9A,       32'h0};
    vecs[16] = '{1, 0, 0, 32'h0,         0, 0, 32'h0,  1, 0,  1, 1,  0, 9, 32'h9A,       32'h0};
    vecs[17] = '{1, 1, 6, 32'h66,        0, 0, 32'h0,  1, 4,  1, 0,  1, 6, 32'h66,       32'h10};
    vecs[18] = '{0, 1, 6, 32'h66,        0, 0, 32'h0,  0, 0,  0, 0,  0, 0, 32'h0,        32'h0};
    vecs[19] = '{1, 0, 0, 32'h0,         0, 0, 32'h0,  0, 0,  1, 1,  0, 0, 32'h0,        32'h0};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      rst = vecs[i].rst;
      ex_valid_i = vecs[i].exv; ex_waddr_i = vecs[i].exa; ex_wdata_i = vecs[i].exd;
      mc_valid_i = vecs[i].mcv; mc_waddr_i = vecs[i].mca; mc_wdata_i = vecs[i].mcd;
      mc_issue_i = vecs[i].iss; mc_issue_rd_i = vecs[i].isr;
      #1;
      chk($sformatf("v%0d_ex_ready", i), ex_ready_o, vecs[i].exr);
      chk($sformatf("v%0d_mc_ready", i), mc_ready_o, vecs[i].mcr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wen", i), reg_wen_o, vecs[i].wen);
      chk($sformatf("v%0d_waddr", i), reg_waddr_o, vecs[i].wa);
      chk($sformatf("v%0d_wdata", i), reg_wdata_o, vecs[i].wd);
      chk($sformatf("v%0d_busy", i), busy_o, SB ? vecs[i].busy : 32'd0);
      @(negedge clk);
    end

    // Hand sequence: MC dropping valid restarts its wait from zero
    rst = 0; ex_valid_i = 0; mc_valid_i = 0; mc_issue_i = 0;
    mstep(dmcr, exf, mcf);
    rst = 1;
    ex_valid_i = 1; ex_waddr_i = 2; ex_wdata_i = 32'hA;
    mc_valid_i = 1; mc_waddr_i = 3; mc_wdata_i = 32'hB;
    mstep(dmcr, exf, mcf);
    mstep(dmcr, exf, mcf);
    mc_valid_i = 0;
    mstep(dmcr, exf, mcf);
    mc_valid_i = 1;
    n = 0;
    while (n < 10) begin
      mstep(dmcr, exf, mcf);
      if (dmcr) break;
      n++;
    end
    chk("starve_after_drop_cycles", n, LIMIT);
    mc_valid_i = 0; ex_valid_i = 0;
    mstep(dmcr, exf, mcf);

    // Randomized traffic against the reference model
    exf = 1; mcf = 1; redo = 0;
    for (int c = 0; c < 500; c++) begin
      if (!ex_valid_i || exf || redo) begin
        ex_valid_i = ($urandom_range(0, 9) < 6);
        ex_waddr_i = 5'($urandom); ex_wdata_i = $urandom;
      end
      if (!mc_valid_i || mcf || redo) begin
        mc_valid_i = ($urandom_range(0, 9) < 5);
        mc_waddr_i = 5'($urandom); mc_wdata_i = $urandom;
      end
      mc_issue_i = ($urandom_range(0, 9) < 3);
      mc_issue_rd_i = 5'($urandom);
      rst = ($urandom_range(0, 59) != 0);
      redo = !rst;
      mstep(dmcr, exf, mcf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
